// File: rtl/deglitch_event_arbiter.sv
// Per-channel glitch filter (2-flop sync + min-width qualification FSM) feeding a
// round-robin arbiter that shares one valid/ready event port between all channels.
module deglitch_event_arbiter #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 11,
   parameter int DEF_MIN_HIGH = 100,
   parameter int DEF_MIN_LOW  = 100
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         sig_in,
   input  logic                    cfg_we,
   input  logic [CNT_W-1:0]        cfg_min_high_in,
   input  logic [CNT_W-1:0]        cfg_min_low_in,
   output logic [N_CH-1:0]         filt_out,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [$clog2(N_CH)-1:0] ev_ch,
   output logic                    ev_rise,
   output logic [N_CH-1:0]         ovf,
   input  logic [N_CH-1:0]         ovf_clr
);

   localparam int CH_W = $clog2(N_CH);

   // state   | meaning
   // LO      | filtered level low, waiting for a high sample
   // QUAL_HI | counting high samples before accepting a rise
   // HI      | filtered level high, waiting for a low sample
   // QUAL_LO | counting low samples before accepting a fall
   localparam logic [1:0] LO      = 2'd0;
   localparam logic [1:0] QUAL_HI = 2'd1;
   localparam logic [1:0] HI      = 2'd2;
   localparam logic [1:0] QUAL_LO = 2'd3;

   logic [N_CH-1:0]  sync_a;
   logic [N_CH-1:0]  s;
   logic [CNT_W-1:0] cfg_min_high;
   logic [CNT_W-1:0] cfg_min_low;
   logic [CNT_W-1:0] thr_hi;
   logic [CNT_W-1:0] thr_lo;
   logic [1:0]       state    [N_CH];
   logic [1:0]       state_nx [N_CH];
   logic [CNT_W-1:0] cnt      [N_CH];
   logic [CNT_W-1:0] cnt_nx   [N_CH];
   logic [N_CH-1:0]  filt_nx;
   logic [N_CH-1:0]  rise_ev;
   logic [N_CH-1:0]  fall_ev;
   logic [N_CH-1:0]  raise;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  pend_rise;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  ovf_set;
   logic [N_CH-1:0]  upd;
   logic             load;
   logic             found;
   logic [CH_W-1:0]  gnt_idx;
   logic [CH_W-1:0]  last_grant;

   assign thr_hi = (cfg_min_high == '0) ? CNT_W'(1) : cfg_min_high;
   assign thr_lo = (cfg_min_low  == '0) ? CNT_W'(1) : cfg_min_low;

   // cnt holds the number of qualifying samples already seen, so reaching the
   // threshold means the run was long enough whatever the current sample is.
   always_comb begin
      filt_nx = filt_out;
      rise_ev = '0;
      fall_ev = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         state_nx[ch] = state[ch];
         cnt_nx[ch]   = cnt[ch];
         case (state[ch])
            LO: begin
               if (s[ch]) begin
                  state_nx[ch] = QUAL_HI;
                  cnt_nx[ch]   = CNT_W'(1);
               end
            end
            QUAL_HI: begin
               if (cnt[ch] >= thr_hi) begin
                  state_nx[ch] = HI;
                  filt_nx[ch]  = 1'b1;
                  rise_ev[ch]  = 1'b1;
               end else if (!s[ch]) begin
                  state_nx[ch] = LO;
               end else if (cnt[ch] != '1) begin
                  cnt_nx[ch] = cnt[ch] + CNT_W'(1);
               end
            end
            HI: begin
               if (!s[ch]) begin
                  state_nx[ch] = QUAL_LO;
                  cnt_nx[ch]   = CNT_W'(1);
               end
            end
            QUAL_LO: begin
               if (cnt[ch] >= thr_lo) begin
                  state_nx[ch] = LO;
                  filt_nx[ch]  = 1'b0;
                  fall_ev[ch]  = 1'b1;
               end else if (s[ch]) begin
                  state_nx[ch] = HI;
               end else if (cnt[ch] != '1) begin
                  cnt_nx[ch] = cnt[ch] + CNT_W'(1);
               end
            end
            default: state_nx[ch] = LO;
         endcase
      end
   end

   // Round-robin: channels above last_grant first, then wrap to the bottom.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int j = 0; j < N_CH; j++) begin
         if (!found && pending[j] && (j > int'(last_grant))) begin
            found   = 1'b1;
            gnt_idx = CH_W'(j);
         end
      end
      for (int j = 0; j < N_CH; j++) begin
         if (!found && pending[j] && (j <= int'(last_grant))) begin
            found   = 1'b1;
            gnt_idx = CH_W'(j);
         end
      end
   end

   assign load    = !ev_valid || ev_ready;
   assign grant   = (load && found) ? (N_CH'(1) << gnt_idx) : '0;
   assign raise   = rise_ev | fall_ev;
   assign ovf_set = raise & pending & ~grant;
   assign upd     = raise & ~ovf_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a       <= '0;
         s            <= '0;
         cfg_min_high <= CNT_W'(DEF_MIN_HIGH);
         cfg_min_low  <= CNT_W'(DEF_MIN_LOW);
         filt_out     <= '0;
         pending      <= '0;
         pend_rise    <= '0;
         ovf          <= '0;
         ev_valid     <= 1'b0;
         ev_ch        <= '0;
         ev_rise      <= 1'b0;
         last_grant   <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            state[ch] <= LO;
            cnt[ch]   <= '0;
         end
      end else begin
         sync_a   <= sig_in;
         s        <= sync_a;
         filt_out <= filt_nx;
         if (cfg_we) begin
            cfg_min_high <= cfg_min_high_in;
            cfg_min_low  <= cfg_min_low_in;
         end
         for (int ch = 0; ch < N_CH; ch++) begin
            state[ch] <= state_nx[ch];
            cnt[ch]   <= cnt_nx[ch];
         end
         pending   <= (pending & ~grant) | raise;
         pend_rise <= (pend_rise & ~upd) | (rise_ev & upd);
         ovf       <= ovf_set | (ovf & ~ovf_clr);
         if (load) begin
            if (found) begin
               ev_valid   <= 1'b1;
               ev_ch      <= gnt_idx;
               ev_rise    <= pend_rise[gnt_idx];
               last_grant <= gnt_idx;
            end else begin
               ev_valid <= 1'b0;
            end
         end
      end
   end

endmodule
